mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle successor to the RV32I single-cycle control unit. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states with a ready handshake on instruction and data memory. It latches the instruction internally, decodes it once, and emits per-state datapath enables. It also flags illegal opcodes into a sticky trap state. It sits between the instruction/data memories and the existing datapath (ALU, register file, PC, load/store extend units).

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = wait on `i_ready`/`d_ready`; 0 = ready inputs ignored and treated as 1.
- `TRAP_EN`, default 1: 1 = an unknown opcode enters TRAP; 0 = an unknown opcode is executed as a NOP (DECODE→FETCH with `pc_en`).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_code` input 32: instruction memory read data, sampled in FETCH.
- `i_ready` input 1: instruction memory data valid.
- `d_ready` input 1: data memory access complete.
- `ir_en` output 1: internal instruction register capture strobe, exported for the datapath IR.
- `pc_en` output 1: PC update strobe.
- `alu_controls` output 4: ALU operation, `{funct7[5],funct3}` encoding.
- `aluSrcMuxSel` output 1: 1 = immediate operand.
- `reg_wr_en` output 1: register file write.
- `d_wr_en` output 1: data memory write.
- `d_rd_en` output 1: data memory read.
- `d_size` output 2: store size; SB=10, SH=01, SW=00.
- `load_type` output 3: load type; LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `RegWdataSel` output 3: writeback source; ALU=000, load=001, LUI=010, AUIPC=011, PC+4=100.
- `branch`, `jal`, `jalr` output 1 each: PC source selects.
- `illegal` output 1: sticky illegal-instruction flag.
- `state_dbg` output 3: current state encoding.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7.
- FETCH
  - `ir_en`=`i_ready`; the internal IR captures `instr_code` on the same edge.
  - Advance to DECODE only when `i_ready`=1; otherwise hold.
- DECODE
  - Register the decoded control word from the IR.
  - Unknown opcode: go to TRAP (`TRAP_EN`=1), or go to FETCH with `pc_en`=1 (`TRAP_EN`=0).
  - Otherwise go to EXECUTE.
- EXECUTE: drive `alu_controls` and `aluSrcMuxSel`. Next state by class:
  - R, I-ALU, LUI, AUIPC, JAL, JALR → WB.
  - S, IL → MEM.
  - B → FETCH with `branch`=1 and `pc_en`=1.
- MEM
  - S: `d_wr_en`=1 and `d_size` valid; on `d_ready` go to FETCH with `pc_en`=1.
  - IL: `d_rd_en`=1 and `load_type` valid; on `d_ready` go to WB.
  - No `d_ready`: hold, with strobes held asserted.
- WB: `reg_wr_en`=1, `RegWdataSel` valid, `pc_en`=1 (with `jal`/`jalr` asserted as applicable), then FETCH.
- TRAP: all enables 0, `illegal`=1; held until `reset`.
- ALU code rules:
  - R-type: `{funct7[5],funct3}`.
  - I-ALU: `{funct7[5],funct3}` only when funct3=101, else `{0,funct3}`.
  - B: `{0,funct3}`.
  - All other classes: ADD (0000).
- Enables and strobes are asserted only in their owning state. Mux selects (`aluSrcMuxSel`, `RegWdataSel`, `d_size`, `load_type`) stay constant from EXECUTE through WB.

## Timing
- Reset (synchronous): state=FETCH; IR=0x00000013 (NOP); all outputs 0; `illegal`=0; `alu_controls`=0000.
- `reset` has priority in every state, including mid-MEM wait and TRAP. Any pending `d_wr_en` drops at the reset edge.
- Latency with zero wait states:
  - Branch: 3 cycles.
  - R/I/U/J: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each cycle of `i_ready`/`d_ready` low adds one cycle.
- Outputs are registered-state decodes (Moore); there is no combinational path from `instr_code` to any output.
- `d_ready` sampled outside MEM is ignored. `i_ready` sampled outside FETCH is ignored.
- With `MEM_HANDSHAKE`=0, FETCH and MEM each last exactly one cycle.
- Unsupported funct3 on S or IL: `d_size`/`load_type`=0 and no trap (matches predecessor behaviour minus X).

## Structure
- Shared package (`define.sv` successor `rv32i_pkg`):
  - Opcode constants.
  - ALU code constants.
  - `state_e` enum.
  - Writeback-select constants.
  - Control-word struct.
- Natural sub-module: `instr_decoder`. It is combinational, maps opcode/funct3/funct7 to the control-word struct plus an `illegal` bit, and is instantiated once on the IR output.

## Test plan
- `reset` held 2 cycles, then released with `i_ready`=1, `d_ready`=1:
  - All outputs 0 and `state_dbg`=0 during reset.
  - `ir_en`=1 on the first cycle after release.
- 0x004182B3 (add x5,x3,x4), no waits:
  - WB reached on cycle 4 with `reg_wr_en`=1, `alu_controls`=0000, `RegWdataSel`=000.
  - `pc_en` pulses exactly once.
- 0x00012083 (lw x1,0(x2)) with `d_ready` low for 3 cycles:
  - `d_rd_en` high for 4 cycles with `load_type`=010.
  - Then WB with `RegWdataSel`=001; total 8 cycles.
- 0x00112223 (sw x1,4(x2)) with `reset` asserted during the second MEM wait cycle:
  - `d_wr_en`=1 and `d_size`=00 before the reset edge.
  - All outputs 0 and state=FETCH after it.
- 0x00000463 (beq): 3 cycles with `branch`=1 and `pc_en`=1 in EXECUTE; `reg_wr_en` never asserted. 0x40315093 (srai) gives `alu_controls`=1101.
- 0x00000000:
  - `TRAP_EN`=1: TRAP entered, `illegal`=1 held for 20 cycles, `ir_en` stays 0.
  - `TRAP_EN`=0: returns to FETCH after DECODE.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/writeback codes, FSM states
// and the registered control word produced by the decoder.
package mc_control_unit_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0]  ALU_ADD   = 4'b0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] WB_ALU   = 3'b000;
  localparam logic [2:0] WB_LOAD  = 3'b001;
  localparam logic [2:0] WB_LUI   = 3'b010;
  localparam logic [2:0] WB_AUIPC = 3'b011;
  localparam logic [2:0] WB_PC4   = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_e;

  // Path an instruction takes once it leaves EXECUTE.
  typedef enum logic [1:0] {F_WB, F_ST, F_LD, F_BR} flow_e;

  typedef struct packed {
    flow_e      flow;
    logic [3:0] alu;
    logic       alu_src;
    logic [2:0] wb_sel;
    logic [1:0] d_size;
    logic [2:0] load_type;
    logic       jal;
    logic       jalr;
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_instr_decoder.sv
// Combinational RV32I decode of the latched instruction into a control word.
module instr_decoder
  import mc_control_unit_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [2:0] f3;
  logic       f7b;
  logic       unused_bits;

  assign f3  = instr[14:12];
  assign f7b = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (instr[6:0])
      OP_R: ctrl.alu = {f7b, f3};
      OP_I: begin
        // only the shift-right pair uses funct7[5]; addi etc. carry imm bits there
        ctrl.alu     = (f3 == 3'b101) ? {f7b, f3} : {1'b0, f3};
        ctrl.alu_src = 1'b1;
      end
      OP_L: begin
        ctrl.flow    = F_LD;
        ctrl.alu_src = 1'b1;
        ctrl.wb_sel  = WB_LOAD;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ctrl.load_type = f3;
          default:                                ctrl.load_type = 3'b000;
        endcase
      end
      OP_S: begin
        ctrl.flow    = F_ST;
        ctrl.alu_src = 1'b1;
        case (f3)
          3'b000:  ctrl.d_size = 2'b10;
          3'b001:  ctrl.d_size = 2'b01;
          default: ctrl.d_size = 2'b00;
        endcase
      end
      OP_B: begin
        ctrl.flow = F_BR;
        ctrl.alu  = {1'b0, f3};
      end
      OP_LUI: begin
        ctrl.alu_src = 1'b1;
        ctrl.wb_sel  = WB_LUI;
      end
      OP_AUIPC: begin
        ctrl.alu_src = 1'b1;
        ctrl.wb_sel  = WB_AUIPC;
      end
      OP_JAL: begin
        ctrl.wb_sel = WB_PC4;
        ctrl.jal    = 1'b1;
      end
      OP_JALR: begin
        ctrl.alu_src = 1'b1;
        ctrl.wb_sel  = WB_PC4;
        ctrl.jalr    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer with
// memory ready handshakes and a sticky TRAP state for illegal opcodes.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  input  logic        i_ready,
  input  logic        d_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic [3:0]  alu_controls,
  output logic        aluSrcMuxSel,
  output logic        reg_wr_en,
  output logic        d_wr_en,
  output logic        d_rd_en,
  output logic [1:0]  d_size,
  output logic [2:0]  load_type,
  output logic [2:0]  RegWdataSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        illegal,
  output logic [2:0]  state_dbg
);
  state_e      state, state_nxt;
  logic [31:0] ir;
  ctrl_t       ctrl_q, dec_ctrl;
  logic        dec_illegal;
  logic        i_rdy, d_rdy;
  logic        sel_on;

  assign i_rdy = MEM_HANDSHAKE ? i_ready : 1'b1;
  assign d_rdy = MEM_HANDSHAKE ? d_ready : 1'b1;

  instr_decoder u_dec (
    .instr   (ir),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // IR and decoded control word; decode happens once, in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= NOP_INSTR;
      ctrl_q <= '0;
    end else begin
      if (state == S_FETCH && i_rdy) ir <= instr_code;
      if (state == S_DECODE)         ctrl_q <= dec_ctrl;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (i_rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) state_nxt = TRAP_EN ? S_TRAP : S_FETCH;
        else             state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (ctrl_q.flow)
          F_ST, F_LD: state_nxt = S_MEM;
          F_BR:       state_nxt = S_FETCH;
          default:    state_nxt = S_WB;
        endcase
      end
      S_MEM:  if (d_rdy) state_nxt = (ctrl_q.flow == F_ST) ? S_FETCH : S_WB;
      S_WB:   state_nxt = S_FETCH;
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ir_en     = (state == S_FETCH) && i_rdy && !reset;
    pc_en     = 1'b0;
    reg_wr_en = 1'b0;
    d_wr_en   = 1'b0;
    d_rd_en   = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    illegal   = 1'b0;
    sel_on    = 1'b0;
    case (state)
      S_DECODE: pc_en = dec_illegal && !TRAP_EN;
      S_EXECUTE: begin
        sel_on = 1'b1;
        branch = (ctrl_q.flow == F_BR);
        pc_en  = (ctrl_q.flow == F_BR);
      end
      S_MEM: begin
        sel_on  = 1'b1;
        d_wr_en = (ctrl_q.flow == F_ST);
        d_rd_en = (ctrl_q.flow == F_LD);
        pc_en   = (ctrl_q.flow == F_ST) && d_rdy;
      end
      S_WB: begin
        sel_on    = 1'b1;
        reg_wr_en = 1'b1;
        pc_en     = 1'b1;
        jal       = ctrl_q.jal;
        jalr      = ctrl_q.jalr;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    // selects are held steady across EXECUTE..WB and parked at zero elsewhere
    alu_controls = sel_on ? ctrl_q.alu       : ALU_ADD;
    aluSrcMuxSel = sel_on ? ctrl_q.alu_src   : 1'b0;
    RegWdataSel  = sel_on ? ctrl_q.wb_sel    : WB_ALU;
    d_size       = sel_on ? ctrl_q.d_size    : 2'b00;
    load_type    = sel_on ? ctrl_q.load_type : 3'b000;
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: per-cycle expected outputs built from instruction-class
// rules, compared against a default DUT and a TRAP_EN=0/MEM_HANDSHAKE=0 DUT.
module tb_mc_control_unit;
  logic        clk = 1'b0;
  logic        reset, reset2, i_ready, d_ready;
  logic [31:0] instr_code;

  logic a_ir, a_pc, a_src, a_rw, a_dw, a_dr, a_br, a_jl, a_jr, a_ill;
  logic [3:0] a_alu; logic [1:0] a_sz; logic [2:0] a_lt, a_wb, a_st;
  logic b_ir, b_pc, b_src, b_rw, b_dw, b_dr, b_br, b_jl, b_jr, b_ill;
  logic [3:0] b_alu; logic [1:0] b_sz; logic [2:0] b_lt, b_wb, b_st;
  logic [24:0] out1, out2;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic        ir_q[$];
  logic        dr_q[$];
  logic [31:0] ic_q[$];

  always #5 clk = ~clk;

  mc_control_unit dut1 (
    .clk(clk), .reset(reset), .instr_code(instr_code), .i_ready(i_ready), .d_ready(d_ready),
    .ir_en(a_ir), .pc_en(a_pc), .alu_controls(a_alu), .aluSrcMuxSel(a_src), .reg_wr_en(a_rw),
    .d_wr_en(a_dw), .d_rd_en(a_dr), .d_size(a_sz), .load_type(a_lt), .RegWdataSel(a_wb),
    .branch(a_br), .jal(a_jl), .jalr(a_jr), .illegal(a_ill), .state_dbg(a_st)
  );

  mc_control_unit #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .instr_code(instr_code), .i_ready(i_ready), .d_ready(d_ready),
    .ir_en(b_ir), .pc_en(b_pc), .alu_controls(b_alu), .aluSrcMuxSel(b_src), .reg_wr_en(b_rw),
    .d_wr_en(b_dw), .d_rd_en(b_dr), .d_size(b_sz), .load_type(b_lt), .RegWdataSel(b_wb),
    .branch(b_br), .jal(b_jl), .jalr(b_jr), .illegal(b_ill), .state_dbg(b_st)
  );

  assign out1 = {a_ir, a_pc, a_alu, a_src, a_rw, a_dw, a_dr, a_sz, a_lt, a_wb, a_br, a_jl, a_jr, a_ill, a_st};
  assign out2 = {b_ir, b_pc, b_alu, b_src, b_rw, b_dw, b_dr, b_sz, b_lt, b_wb, b_br, b_jl, b_jr, b_ill, b_st};

  function automatic logic [24:0] mk(bit ir, bit pc, logic [3:0] alu, bit src, bit rw, bit dw, bit dr,
                                     logic [1:0] sz, logic [2:0] lt, logic [2:0] wb, bit br, bit jl,
                                     bit jr, bit ill, logic [2:0] st);
    return {ir, pc, alu, src, rw, dw, dr, sz, lt, wb, br, jl, jr, ill, st};
  endfunction

  // 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, -1 unknown
  function automatic int ref_class(logic [31:0] ins);
    case (ins[6:0])
      7'h33: return 0;  7'h13: return 1;  7'h03: return 2;
      7'h23: return 3;  7'h63: return 4;  7'h37: return 5;
      7'h17: return 6;  7'h6F: return 7;  7'h67: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr(bit allow_ill);
    logic [31:0] ins;
    logic [6:0]  ops [9];
    logic [6:0]  bad [4];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    bad = '{7'h00, 7'h7F, 7'h0B, 7'h5B};
    ins = $urandom;
    if (allow_ill && $urandom_range(0, 4) == 0) ins[6:0] = bad[$urandom_range(0, 3)];
    else                                         ins[6:0] = ops[$urandom_range(0, 8)];
    return ins;
  endfunction

  task automatic push(bit ir, bit dr, logic [31:0] ic, logic [24:0] e);
    ir_q.push_back(ir); dr_q.push_back(dr); ic_q.push_back(ic); exp_q.push_back(e);
  endtask

  // Expected per-cycle trace for one instruction: fetch waits, then the
  // class-dependent walk through decode/execute/mem/writeback.
  task automatic build(logic [31:0] ins, int iw, int dw, bit trap_en, bit hs, int trap_cyc);
    int cls;
    logic [2:0] f3, wb, lt;
    logic [3:0] alu;
    logic [1:0] sz;
    bit src, f7b, st, ld;
    cls = ref_class(ins);
    f3  = ins[14:12];
    f7b = ins[30];
    if (!hs) begin iw = 0; dw = 0; end
    alu = (cls == 0) ? {f7b, f3} : (cls == 1) ? ((f3 == 3'd5) ? {f7b, f3} : {1'b0, f3}) :
          (cls == 4) ? {1'b0, f3} : 4'd0;
    src = (cls == 1 || cls == 2 || cls == 3 || cls == 5 || cls == 6 || cls == 8);
    wb  = (cls == 2) ? 3'd1 : (cls == 5) ? 3'd2 : (cls == 6) ? 3'd3 : (cls >= 7) ? 3'd4 : 3'd0;
    sz  = (cls != 3) ? 2'd0 : (f3 == 3'd0) ? 2'b10 : (f3 == 3'd1) ? 2'b01 : 2'b00;
    lt  = (cls == 2 && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) ? f3 : 3'd0;
    st  = (cls == 3);
    ld  = (cls == 2);
    for (int k = 0; k < iw; k++)
      push(1'b0, 1'($urandom), $urandom, mk(0,0,4'd0,0,0,0,0,2'd0,3'd0,3'd0,0,0,0,0,3'd0));
    push(hs ? 1'b1 : 1'($urandom), 1'($urandom), ins, mk(1,0,4'd0,0,0,0,0,2'd0,3'd0,3'd0,0,0,0,0,3'd0));
    push(1'($urandom), 1'($urandom), $urandom,
         mk(0, (cls < 0 && !trap_en),4'd0,0,0,0,0,2'd0,3'd0,3'd0,0,0,0,0,3'd1));
    if (cls < 0) begin
      if (trap_en)
        for (int k = 0; k < trap_cyc; k++)
          push(1'($urandom), 1'($urandom), $urandom, mk(0,0,4'd0,0,0,0,0,2'd0,3'd0,3'd0,0,0,0,1,3'd7));
      return;
    end
    push(1'($urandom), 1'($urandom), $urandom, mk(0,(cls == 4),alu,src,0,0,0,sz,lt,wb,(cls == 4),0,0,0,3'd2));
    if (cls == 4) return;
    if (st || ld) begin
      for (int k = 0; k < dw; k++)
        push(1'($urandom), 1'b0, $urandom, mk(0,0,alu,src,0,st,ld,sz,lt,wb,0,0,0,0,3'd3));
      push(1'($urandom), hs ? 1'b1 : 1'($urandom), $urandom, mk(0,st,alu,src,0,st,ld,sz,lt,wb,0,0,0,0,3'd3));
      if (st) return;
    end
    push(1'($urandom), 1'($urandom), $urandom, mk(0,1,alu,src,1,0,0,sz,lt,wb,0,(cls == 7),(cls == 8),0,3'd4));
  endtask

  // Plays the queued trace into one DUT, one cycle per entry; optional reset at step rst_at.
  task automatic run_q(bit which, int rst_at, string tag);
    logic [24:0] got;
    for (int k = 0; k < exp_q.size(); k++) begin
      i_ready = ir_q[k]; d_ready = dr_q[k]; instr_code = ic_q[k];
      if (k == rst_at) reset = 1'b1;
      #1;
      got = which ? out2 : out1;
      checks++;
      if (got !== exp_q[k]) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", tag, k, got, exp_q[k]);
      end
      @(negedge clk);
    end
    exp_q.delete(); ir_q.delete(); dr_q.delete(); ic_q.delete();
  endtask

  task automatic do_reset(bit which);
    if (which) reset2 = 1'b1; else reset = 1'b1;
    i_ready = 1'b1; d_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ((which ? out2 : out1) !== 25'd0) begin
      errors++;
      $display("FAIL reset_dut%0d: got %h expected 0", which + 1, which ? out2 : out1);
    end
    if (which) reset2 = 1'b0; else reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1; i_ready = 1'b1; d_ready = 1'b1; instr_code = '0;
    repeat (2) begin
      @(negedge clk); #1;
      checks += 2;
      if (out1 !== 25'd0) begin errors++; $display("FAIL reset_hold dut1: got %h expected 0", out1); end
      if (out2 !== 25'd0) begin errors++; $display("FAIL reset_hold dut2: got %h expected 0", out2); end
    end
    reset = 1'b0; reset2 = 1'b0;
  endtask

  task automatic test_add();
    build(32'h004182B3, 0, 0, 1, 1, 0);
    run_q(0, -1, "add");
  endtask

  task automatic test_load_wait();
    build(32'h00012083, 0, 3, 1, 1, 0);
    run_q(0, -1, "lw_wait3");
  endtask

  task automatic test_store_reset();
    build(32'h00112223, 0, 5, 1, 1, 0);
    while (exp_q.size() > 5) begin
      void'(exp_q.pop_back()); void'(ir_q.pop_back()); void'(dr_q.pop_back()); void'(ic_q.pop_back());
    end
    run_q(0, 4, "sw_mid_reset");
    i_ready = 1'b1; #1;
    checks++;
    if (out1 !== 25'd0) begin errors++; $display("FAIL sw_after_reset: got %h expected 0", out1); end
    reset = 1'b0;
  endtask

  task automatic test_branch_shift();
    build(32'h00000463, 0, 0, 1, 1, 0);
    build(32'h40315093, 1, 0, 1, 1, 0);
    run_q(0, -1, "beq_srai");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      build(rand_instr(1'b0), $urandom_range(0, 3), $urandom_range(0, 3), 1, 1, 0);
    run_q(0, -1, "random");
  endtask

  task automatic test_trap();
    build(32'h00000000, 0, 0, 1, 1, 20);
    run_q(0, -1, "trap");
    do_reset(0);
    build(32'h004182B3, 0, 0, 1, 1, 0);
    run_q(0, -1, "after_trap");
  endtask

  task automatic test_no_trap_no_handshake();
    do_reset(1);
    build(32'h00000000, 0, 0, 0, 0, 0);
    build(32'h004182B3, 0, 0, 0, 0, 0);
    build(32'h00012083, 0, 0, 0, 0, 0);
    build(32'h00112223, 0, 0, 0, 0, 0);
    for (int n = 0; n < 30; n++) build(rand_instr(1'b1), 0, 0, 0, 0, 0);
    run_q(1, -1, "notrap_nohs");
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store_reset();
    test_branch_shift();
    test_random();
    test_trap();
    test_no_trap_no_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
